// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: N requesters share one fifo write port.
// A grant lasts until max_burst words have moved or the owner withdraws.
//
// state | meaning
// ARB   | no owner; pick the next valid requester after last_grant
// GRANT | grant_id owns the fifo write port until burst end or withdrawal
module fifo_wr_arbiter #(
    parameter int data_word_size = 8,
    parameter int num_requesters = 4,
    parameter int max_burst      = 4,
    localparam int ID_W = (num_requesters > 1) ? $clog2(num_requesters) : 1
) (
    input  logic                                     clk,
    input  logic                                     reset,
    input  logic                                     clk_en,
    input  logic [num_requesters-1:0]                req_valid,
    input  logic [num_requesters*data_word_size-1:0] req_data,
    output logic [num_requesters-1:0]                req_ready,
    input  logic                                     fifo_w_full,
    output logic                                     fifo_w_en,
    output logic [data_word_size-1:0]                fifo_w_data,
    output logic [ID_W-1:0]                          grant_id,
    output logic                                     grant_active
);

    typedef enum logic {
        ARB   = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam logic [7:0]      LAST_CNT = 8'(max_burst - 1);
    localparam logic [ID_W-1:0] LAST_ID  = ID_W'(num_requesters - 1);
    localparam logic [ID_W-1:0] ONE_ID   = ID_W'(1);

    state_t          state_q;
    logic [7:0]      burst_cnt_q;
    logic [ID_W-1:0] grant_id_q;
    logic [ID_W-1:0] last_grant_q;
    logic            grant_active_q;

    logic [ID_W-1:0] pick_idx;
    logic [ID_W-1:0] cand;
    logic            pick_found;
    logic            owner_valid;
    logic            transfer;

    // Search order starts one past the previous owner and wraps.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = last_grant_q;
        for (int k = 0; k < num_requesters; k++) begin
            cand = (cand == LAST_ID) ? '0 : cand + ONE_ID;
            if (!pick_found && req_valid[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    assign owner_valid = req_valid[grant_id_q];
    assign transfer    = (state_q == GRANT) & clk_en & owner_valid & ~fifo_w_full & ~reset;

    always_comb begin
        req_ready = '0;
        if (transfer) begin
            req_ready[grant_id_q] = 1'b1;
        end
    end

    assign fifo_w_en    = transfer;
    assign fifo_w_data  = req_data[grant_id_q*data_word_size +: data_word_size];
    assign grant_id     = grant_id_q;
    assign grant_active = grant_active_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ARB;
            burst_cnt_q    <= '0;
            grant_id_q     <= '0;
            last_grant_q   <= LAST_ID;
            grant_active_q <= 1'b0;
        end else if (clk_en) begin
            case (state_q)
                ARB: begin
                    if (pick_found) begin
                        state_q        <= GRANT;
                        grant_id_q     <= pick_idx;
                        burst_cnt_q    <= '0;
                        grant_active_q <= 1'b1;
                    end
                end
                GRANT: begin
                    if (!owner_valid) begin
                        state_q        <= ARB;
                        last_grant_q   <= grant_id_q;
                        grant_active_q <= 1'b0;
                    end else if (!fifo_w_full) begin
                        burst_cnt_q <= burst_cnt_q + 8'd1;
                        if (burst_cnt_q == LAST_CNT) begin
                            state_q        <= ARB;
                            last_grant_q   <= grant_id_q;
                            grant_active_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q        <= ARB;
                    grant_active_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter data_word_size, default 8, width of each data word.
REQ-002 Parameter num_requesters, default 4, number of write requesters (range 2..8).
REQ-003 Parameter max_burst, default 4, maximum words per grant (range 1..255).
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port reset  input  1  synchronous, active-high reset.
REQ-006 Port clk_en  input  1  state-advance enable; when low, no state changes and no transfers.
REQ-007 Port req_valid  input  num_requesters  per-requester word-available flag.
REQ-008 Port req_data  input  num_requesters*data_word_size  packed words; requester i occupies bits [i*data_word_size +: data_word_size].
REQ-009 Port req_ready  output  num_requesters  per-requester word-accepted strobe.
REQ-010 Port fifo_w_full  input  1  full flag from the shared fifo write port.
REQ-011 Port fifo_w_en  output  1  write enable to the fifo.
REQ-012 Port fifo_w_data  output  data_word_size  write data to the fifo.
REQ-013 Port grant_id  output  clog2(num_requesters)  index of the current owner.
REQ-014 Port grant_active  output  1  high while in GRANT state.

Function
REQ-015 The block SHALL implement two states: ARB and GRANT.
REQ-016 In ARB with clk_en high and any req_valid high, the block SHALL select the first requester with valid high, searching round-robin from (last_grant+1) mod num_requesters, and SHALL enter GRANT on the next edge with grant_id set to that index.
REQ-017 In ARB with no req_valid high, the block SHALL remain in ARB and keep grant_id unchanged.
REQ-018 In ARB, fifo_w_en and all req_ready bits SHALL be 0; arbitration latency is therefore exactly one cycle.
REQ-019 In GRANT, transfer = clk_en & req_valid[grant_id] & ~fifo_w_full, combinational.
REQ-020 fifo_w_en SHALL equal transfer; req_ready[grant_id] SHALL equal transfer; all other req_ready bits SHALL be 0.
REQ-021 fifo_w_data SHALL equal the req_data slice of grant_id at all times (don't-care when fifo_w_en is low).
REQ-022 The 8-bit burst counter SHALL clear on entry to GRANT and increment by 1 on each transfer.
REQ-023 GRANT SHALL exit to ARB on the edge where a transfer occurs with counter = max_burst-1.
REQ-024 GRANT SHALL exit to ARB on any clk_en-high edge where req_valid[grant_id] is low (requester withdrawn), with no transfer that cycle.
REQ-025 While fifo_w_full is high in GRANT, the block SHALL hold state and counter (no timeout) and SHALL retain ownership.
REQ-026 last_grant SHALL update to grant_id on every exit from GRANT; the next arbitration SHALL start after it, so no requester waits more than num_requesters-1 grants.
REQ-027 When clk_en is low, the block SHALL hold state, counter, grant_id and last_grant, and fifo_w_en/req_ready SHALL be 0.
REQ-028 Valid changes on non-owner requesters during GRANT SHALL have no effect until the next ARB cycle.

Reset
REQ-029 On a clk edge with reset high, irrespective of clk_en, state SHALL become ARB, counter 0, grant_id 0, and last_grant num_requesters-1 (so requester 0 has first priority).
REQ-030 During and after reset, fifo_w_en=0, req_ready=0 and grant_active=0 until a grant is issued.
REQ-031 Reset asserted mid-GRANT SHALL abort the burst on that edge; the word presented in the reset cycle SHALL NOT be written (fifo_w_en forced 0 while reset is high).

Verification
REQ-032 Reset, then req_valid=4'b0001 with data 15,69,42 and valid dropped after the third transfer -> one ARB cycle, three consecutive fifo_w_en pulses carrying 15,69,42, then ARB with grant_active=0.
REQ-033 All four requesters continuously valid, max_burst=4 -> grants in order 0,1,2,3,0; exactly 4 writes per grant; one idle ARB cycle between grants.
REQ-034 Requester 2 granted, fifo_w_full high for 5 cycles mid-burst -> no writes and req_ready=0 during those cycles, counter held, burst completes after full deasserts, total 4 words.
REQ-035 clk_en low for 3 cycles during GRANT with valid high -> fifo_w_en=0, state and counter unchanged, transfers resume when clk_en returns.
REQ-036 Reset pulsed while requester 1 is at word 2 of its burst -> no write on the reset cycle; afterwards grant_active=0 and the next grant goes to the lowest-index valid requester starting from 0.
REQ-037 Requester 3 only valid, then requester 0 asserts valid during requester 3's burst -> requester 0 ignored until requester 3 exits, then granted next.
